// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM access sequencer and its lane unit.
package dram_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CTRL_UNS = 2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE,
        ST_ERR
    } state_t;

    // True when size is illegal or the address is not aligned to it.
    function automatic logic is_bad_access(logic [1:0] size, logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lo[0];
            SZ_W:    bad = (lo != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dram_lane_unit.sv
// Byte/half lane extraction with sign extension, and sub-word merge into a read word.
module dram_lane_unit
    import dram_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] ext_data,
    output logic [31:0] merged_word
);

    logic [4:0]  b_sh;
    logic [4:0]  h_sh;
    logic [7:0]  b_lane;
    logic [15:0] h_lane;
    logic [31:0] mask;
    logic [31:0] ins;

    // Select lane, extend for loads, and overlay store bits onto the read word.
    always_comb begin
        b_sh     = {addr_lo, 3'b000};
        h_sh     = {addr_lo[1], 4'b0000};
        b_lane   = 8'(rword >> b_sh);
        h_lane   = 16'(rword >> h_sh);
        ext_data = rword;
        mask     = '1;
        ins      = wdata;
        case (size)
            SZ_B: begin
                ext_data = uns ? {24'd0, b_lane} : {{24{b_lane[7]}}, b_lane};
                mask     = 32'h0000_00FF << b_sh;
                ins      = {24'd0, wdata[7:0]} << b_sh;
            end
            SZ_H: begin
                ext_data = uns ? {16'd0, h_lane} : {{16{h_lane[15]}}, h_lane};
                mask     = 32'h0000_FFFF << h_sh;
                ins      = {16'd0, wdata[15:0]} << h_sh;
            end
            default: ;
        endcase
        merged_word = (rword & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/dram_access_seq.sv
// Runs one granted load/store against a word-wide memory port; sub-word stores use read-modify-write.
module dram_access_seq
    import dram_pkg::*;
#(
    parameter int unsigned MEM_AW  = 24,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       dram_addr,
    input  logic [31:0]       dram_wdata,
    input  logic [2:0]        dram_ctrl,
    input  logic              dram_le,
    input  logic              dram_we_t,
    output logic              dram_busy,
    output logic [31:0]       dram_odata,
    output logic              dram_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        tmo_q, tmo_d;
    logic [1:0]        lo_q, lo_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              store_q, store_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_d, req_d, we_d, err_d;
    logic [31:0]       odata_d, mem_wdata_d;
    logic [MEM_AW-1:0] mem_addr_d;
    logic [31:0]       ext_data, merged_word;
    logic              unused_addr;

    // Upper address bits beyond the memory port are intentionally dropped.
    assign unused_addr = ^dram_addr;

    dram_lane_unit u_lane (
        .addr_lo     (lo_q),
        .size        (size_q),
        .uns         (uns_q),
        .rword       (mem_rdata),
        .wdata       (wdata_q),
        .ext_data    (ext_data),
        .merged_word (merged_word)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        lo_d        = lo_q;
        size_d      = size_q;
        uns_d       = uns_q;
        store_d     = store_q;
        wdata_d     = wdata_q;
        odata_d     = dram_odata;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        case (state_q)
            ST_IDLE: begin
                if ((dram_le || dram_we_t) && !dram_busy) begin
                    lo_d       = dram_addr[1:0];
                    size_d     = dram_ctrl[1:0];
                    uns_d      = dram_ctrl[CTRL_UNS];
                    store_d    = dram_we_t;
                    wdata_d    = dram_wdata;
                    mem_addr_d = dram_addr[MEM_AW+1:2];
                    tmo_d      = 8'd0;
                    if (is_bad_access(dram_ctrl[1:0], dram_addr[1:0])) begin
                        state_d = ST_ERR;
                    end else if (dram_we_t && dram_ctrl[1:0] == SZ_W) begin
                        state_d     = ST_WR;
                        mem_wdata_d = dram_wdata;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    if (store_q) begin
                        mem_wdata_d = merged_word;
                        tmo_d       = 8'd0;
                        state_d     = ST_WR;
                    end else begin
                        odata_d = ext_data;
                        state_d = ST_DONE;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_q == TMO_LAST) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_WR: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_q == TMO_LAST) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        req_d  = (state_d == ST_RD) || (state_d == ST_WR);
        we_d   = (state_d == ST_WR);
        err_d  = (state_d == ST_ERR);
    end

    // State, request context and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            tmo_q      <= 8'd0;
            lo_q       <= 2'd0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            store_q    <= 1'b0;
            wdata_q    <= 32'd0;
            dram_busy  <= 1'b0;
            dram_odata <= 32'd0;
            dram_err   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            lo_q       <= lo_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            store_q    <= store_d;
            wdata_q    <= wdata_d;
            dram_busy  <= busy_d;
            dram_odata <= odata_d;
            dram_err   <= err_d;
            mem_req    <= req_d;
            mem_we     <= we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

endmodule
